// File: rtl/ov7670_init_sequencer.sv
// OV7670 bring-up sequencer: sensor pin power-up timing, then a table-driven
// walk that issues (register, value) writes to the SCCB master or inserts ms delays.
`timescale 1ns/1ps
module ov7670_init_sequencer #(
   parameter int MS_CYCLES   = 50000,
   parameter int RST_LOW_MS  = 1,
   parameter int PWRUP_MS    = 3,
   parameter int ROM_AW      = 8,
   parameter int ACK_TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [7:0]        cmd_reg,
   output logic [7:0]        cmd_data,
   input  logic              cmd_done,
   output logic              ov7670_rst_n,
   output logic              ov7670_pwdn,
   output logic              done,
   output logic              error
);

   localparam int PW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [PW-1:0]     PRESC_MAX = PW'(MS_CYCLES - 1);
   localparam logic [WW-1:0]     WAIT_MAX  = WW'(ACK_TIMEOUT - 1);
   localparam logic [ROM_AW-1:0] ADDR_LAST = '1;
   localparam logic [15:0]       END_MARK  = 16'hFFFF;
   localparam logic [7:0]        DELAY_REG = 8'hF0;

   typedef enum logic [3:0] {
      S_RST, S_PWRUP, S_FETCH, S_DECODE, S_CMD, S_WAIT, S_DELAY, S_NEXT, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [PW-1:0]     r_presc;
   logic [7:0]        r_ms;
   logic [7:0]        r_delay_ms;
   logic [WW-1:0]     r_wait;
   logic [ROM_AW-1:0] r_rom_addr;
   logic [7:0]        r_cmd_reg;
   logic [7:0]        r_cmd_data;
   logic              r_error;
   logic [7:0]        w_ms_target;
   logic              w_ms_done;
   logic              w_enter;

   // Millisecond budget of whichever timed state is currently active.
   always_comb begin
      w_ms_target = r_delay_ms;
      case (r_state)
         S_RST:   w_ms_target = 8'(RST_LOW_MS);
         S_PWRUP: w_ms_target = 8'(PWRUP_MS);
         default: ;
      endcase
   end

   assign w_ms_done = (r_presc == PRESC_MAX) && (r_ms == w_ms_target - 8'd1);
   assign w_enter   = (w_next != r_state);

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:    if (w_ms_done) w_next = S_PWRUP;
         S_PWRUP:  if (w_ms_done) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (rom_data == END_MARK)             w_next = S_DONE;
            else if (rom_data[15:8] == DELAY_REG) w_next = (rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
            else                                  w_next = S_CMD;
         end
         S_CMD:    if (cmd_ready) w_next = S_WAIT;
         S_WAIT: begin
            if (cmd_done)                w_next = S_NEXT;
            else if (r_wait == WAIT_MAX) w_next = S_DONE;
         end
         S_DELAY:  if (w_ms_done) w_next = S_NEXT;
         S_NEXT:   w_next = (r_rom_addr == ADDR_LAST) ? S_DONE : S_FETCH;
         S_DONE:   if (restart) w_next = S_RST;
         default:  w_next = S_RST;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_RST;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc    <= '0;
         r_ms       <= '0;
         r_wait     <= '0;
         r_delay_ms <= '0;
         r_rom_addr <= '0;
         r_cmd_reg  <= '0;
         r_cmd_data <= '0;
         r_error    <= 1'b0;
      end else begin
         // Timers restart from zero on every state entry.
         if (w_enter) begin
            r_presc <= '0;
            r_ms    <= '0;
            r_wait  <= '0;
         end else begin
            if (r_presc == PRESC_MAX) begin
               r_presc <= '0;
               r_ms    <= r_ms + 8'd1;
            end else begin
               r_presc <= r_presc + PW'(1);
            end
            r_wait <= r_wait + WW'(1);
         end

         case (r_state)
            S_PWRUP:  if (w_next == S_FETCH) r_rom_addr <= '0;
            S_DECODE: begin
               if (w_next == S_CMD) begin
                  r_cmd_reg  <= rom_data[15:8];
                  r_cmd_data <= rom_data[7:0];
               end else if (w_next == S_DELAY) begin
                  r_delay_ms <= rom_data[7:0];
               end else if (w_next == S_DONE) begin
                  r_error <= 1'b0;
               end
            end
            S_WAIT:   if (w_next == S_DONE) r_error <= 1'b1;
            S_NEXT: begin
               if (w_next == S_DONE) r_error    <= 1'b1;
               else                  r_rom_addr <= r_rom_addr + ROM_AW'(1);
            end
            S_DONE: begin
               if (w_next == S_RST) begin
                  r_error    <= 1'b0;
                  r_rom_addr <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Decoded from the state so cmd_valid and the pins follow an asynchronous reset at once.
   assign cmd_valid    = (r_state == S_CMD);
   assign done         = (r_state == S_DONE);
   assign ov7670_pwdn  = (r_state == S_RST);
   assign ov7670_rst_n = (r_state != S_RST);
   assign rom_addr     = r_rom_addr;
   assign cmd_reg      = r_cmd_reg;
   assign cmd_data     = r_cmd_data;
   assign error        = r_error;

endmodule

// File: tb/tb_ov7670_init_sequencer.sv
// Scoreboard bench for ov7670_init_sequencer: a table-walking reference model predicts
// every transfer (reg, data, accept cycle) and the done cycle/error/final index.
`timescale 1ns/1ps
module tb_ov7670_init_sequencer;

   localparam int MS      = 10;
   localparam int RST_LOW = 1;
   localparam int PWRUP   = 3;
   localparam int AW      = 2;
   localparam int ACK     = 50;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          restart = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_data = 16'h0000;
   logic          cmd_valid;
   logic          cmd_ready = 1'b0;
   logic [7:0]    cmd_reg;
   logic [7:0]    cmd_data;
   logic          cmd_done = 1'b0;
   logic          ov7670_rst_n;
   logic          ov7670_pwdn;
   logic          done;
   logic          error;

   always #5 clk = ~clk;

   ov7670_init_sequencer #(
      .MS_CYCLES(MS), .RST_LOW_MS(RST_LOW), .PWRUP_MS(PWRUP), .ROM_AW(AW), .ACK_TIMEOUT(ACK)
   ) dut (
      .clk(clk), .rst(rst), .restart(restart), .rom_addr(rom_addr), .rom_data(rom_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
      .cmd_done(cmd_done), .ov7670_rst_n(ov7670_rst_n), .ov7670_pwdn(ov7670_pwdn),
      .done(done), .error(error)
   );

   // Synchronous table ROM: data valid one cycle after the address.
   logic [15:0] rom_mem [4];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   typedef struct {
      logic [7:0] r;
      logic [7:0] d;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   exp_done_cyc = 0;
   int   exp_err      = 0;
   int   exp_addr     = 0;
   int   bp_cfg       = 0;
   int   lat_cfg      = 5;
   int   restart_req  = 0;
   bit   noise_en     = 1'b1;
   int   n_checks     = 0;
   int   n_fail       = 0;

   task automatic check_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: walk the table entry by entry and accumulate cycle costs.
   // Times are edges counted from the edge on which the sensor pins are released.
   task automatic build_expect();
      int t;
      logic [15:0] e;
      t = PWRUP * MS;
      for (int i = 0; i < 4; i++) begin
         e = rom_mem[i];
         t += 2;
         if (e == 16'hFFFF) begin
            exp_err = 0; exp_addr = i; exp_done_cyc = t;
            return;
         end
         if (e[15:8] == 8'hF0) begin
            t += int'(e[7:0]) * MS;
         end else begin
            t += bp_cfg + 1;
            exp_q.push_back('{e[15:8], e[7:0], t});
            if (lat_cfg == 0) begin
               exp_err = 1; exp_addr = i; exp_done_cyc = t + ACK;
               return;
            end
            t += lat_cfg;
         end
         t += 1;
      end
      exp_err = 1; exp_addr = 3; exp_done_cyc = t;
   endtask

   // SCCB-side responder: backpressure, delayed cmd_done, ignored-input noise, restarts.
   task automatic responder();
      int bp_cnt = 0;
      int remaining = 0;
      int restart_ack = 0;
      bit xfer;
      forever begin
         @(negedge clk);
         xfer = rst && cmd_valid && cmd_ready;
         @(posedge clk);
         #1;
         if (!rst) begin
            cmd_ready = 1'b0; cmd_done = 1'b0; restart = 1'b0; remaining = 0; bp_cnt = bp_cfg;
         end else begin
            if (xfer) remaining = lat_cfg;
            cmd_done = (remaining == 1);
            if (remaining > 0) remaining--;
            if (cmd_valid) begin
               if (bp_cnt > 0) begin
                  cmd_ready = 1'b0;
                  bp_cnt--;
                  if (noise_en && $urandom_range(0, 3) == 0) cmd_done = 1'b1;
               end else begin
                  cmd_ready = 1'b1;
               end
            end else begin
               bp_cnt    = bp_cfg;
               cmd_ready = noise_en && ($urandom_range(0, 2) == 0);
            end
            if (restart_ack != restart_req && done) begin
               restart = 1'b1;
               restart_ack++;
            end else begin
               restart = noise_en && !done && ($urandom_range(0, 15) == 0);
            end
         end
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and checks pin and done timing.
   task automatic monitor();
      int cyc = 0;
      int lowcnt = 0;
      bit prev_rst_n = 1'b0, prev_done = 1'b0, prev_valid = 1'b0, prev_xfer = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cyc = 0; lowcnt = 0;
            prev_rst_n = 1'b0; prev_done = 1'b0; prev_valid = 1'b0; prev_xfer = 1'b0;
         end else begin
            cyc++;
            if (ov7670_rst_n && !prev_rst_n) begin
               check_eq("rst_low_cycles", lowcnt, RST_LOW * MS);
               check_eq("pwdn_released", ov7670_pwdn, 0);
               cyc = 0;
               lowcnt = 0;
            end else if (!ov7670_rst_n) begin
               lowcnt++;
               check_eq("pwdn_in_reset", ov7670_pwdn, 1);
            end
            prev_rst_n = ov7670_rst_n;
            if (prev_valid && !cmd_valid) check_eq("valid_held_until_xfer", prev_xfer, 1);
            if (cmd_valid) begin
               check_eq("cmd_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  check_eq("cmd_reg", cmd_reg, exp_q[0].r);
                  check_eq("cmd_data", cmd_data, exp_q[0].d);
                  if (cmd_ready) begin
                     check_eq("accept_cycle", cyc + 1, exp_q[0].cyc);
                     void'(exp_q.pop_front());
                  end
               end
            end
            prev_valid = cmd_valid;
            prev_xfer  = cmd_valid && cmd_ready;
            if (done && !prev_done) begin
               check_eq("done_cycle", cyc, exp_done_cyc);
               check_eq("cmds_outstanding", exp_q.size(), 0);
            end
            prev_done = done;
         end
      end
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      rom_mem[0] = a; rom_mem[1] = b; rom_mem[2] = c; rom_mem[3] = d;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check_eq("done_reached", done, 1);
      check_eq("error_flag", error, exp_err);
      check_eq("rom_addr_final", rom_addr, exp_addr);
      check_eq("pwdn_in_done", ov7670_pwdn, 0);
      check_eq("rst_n_in_done", ov7670_rst_n, 1);
   endtask

   task automatic check_reset_values();
      check_eq("rst_cmd_valid", cmd_valid, 0);
      check_eq("rst_cmd_reg", cmd_reg, 0);
      check_eq("rst_cmd_data", cmd_data, 0);
      check_eq("rst_rom_addr", rom_addr, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_pwdn", ov7670_pwdn, 1);
      check_eq("rst_rst_n", ov7670_rst_n, 0);
   endtask

   task automatic start_from_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      exp_q.delete();
      build_expect();
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic run_from_reset();
      start_from_reset();
      wait_done();
   endtask

   task automatic run_restart();
      int n = 0;
      exp_q.delete();
      build_expect();
      restart_req++;
      while (done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("restart_done_cleared", done, 0);
      check_eq("restart_error_cleared", error, 0);
      check_eq("restart_pwdn", ov7670_pwdn, 1);
      check_eq("restart_rst_n", ov7670_rst_n, 0);
      wait_done();
   endtask

   initial begin
      load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      fork
         responder();
         monitor();
      join_none

      // Two writes, end marker, then backpressure on the same table.
      load(16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
      bp_cfg = 0; lat_cfg = 5;
      run_from_reset();
      bp_cfg = 7;
      run_restart();

      // Data-driven delays: 2 ms, then a zero-length delay entry.
      bp_cfg = 0; lat_cfg = 3;
      load(16'hF002, 16'h3A04, 16'hFFFF, 16'h0000);
      run_restart();
      load(16'hF000, 16'h3A04, 16'hFFFF, 16'h0000);
      run_restart();

      // Missing cmd_done: timeout, then a clean rerun.
      load(16'h1280, 16'h1100, 16'hFFFF, 16'h0000);
      lat_cfg = 0;
      run_restart();
      lat_cfg = 5;
      run_restart();

      // Reset while a command is stalled by backpressure.
      begin
         int n = 0;
         bp_cfg = 40;
         start_from_reset();
         while (!cmd_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
         check_eq("reached_cmd", cmd_valid, 1);
         repeat (3) @(posedge clk);
         #3 rst = 1'b0;
         #1 check_reset_values();
         bp_cfg = 0;
         run_from_reset();
      end

      // No end marker: index saturates at the last entry and flags an error.
      lat_cfg = 2;
      load(16'h1280, 16'hF001, 16'h1100, 16'hF000);
      run_restart();

      // Randomized tables, latencies and backpressure.
      for (int k = 0; k < 24; k++) begin
         logic [15:0] tbl [4];
         for (int i = 0; i < 4; i++) begin
            int sel;
            logic [7:0] r8, d8;
            sel = $urandom_range(0, 9);
            r8  = 8'($urandom_range(0, 255));
            d8  = 8'($urandom_range(0, 255));
            if (sel < 5 || sel == 9) begin
               if (r8 == 8'hF0) r8 = 8'hF1;
               if (r8 == 8'hFF && d8 == 8'hFF) d8 = 8'h00;
               tbl[i] = {r8, d8};
            end else if (sel < 7) begin
               tbl[i] = {8'hF0, 8'($urandom_range(0, 3))};
            end else begin
               tbl[i] = 16'hFFFF;
            end
         end
         load(tbl[0], tbl[1], tbl[2], tbl[3]);
         bp_cfg  = $urandom_range(0, 4);
         lat_cfg = $urandom_range(0, 7);
         if (k % 3 == 0) run_from_reset();
         else            run_restart();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ov7670_init_sequencer.md
Name: ov7670_init_sequencer

Overview:
- Sequences OV7670 bring-up: power-down/reset pin timing, then walks an external register table and issues each (register, value) pair to the SCCB write master through a valid/ready command handshake.
- Sits inside top_ov7670 between the clock/reset tree (FCCC GL0, POWER_ON_RESET_N AND LOCK) and the SCCB master, and drives the sensor control pins and the done flag.
- Table entries also encode delays and end-of-table, so init timing is data-driven.

Parameters:
- MS_CYCLES, 50000: clk cycles per millisecond (50 MHz GL0).
- RST_LOW_MS, 1: ms to hold ov7670_rst_n low with pwdn high.
- PWRUP_MS, 3: ms to wait after releasing reset and pwdn, before the first table fetch.
- ROM_AW, 8: table address width (max 2^ROM_AW entries).
- ACK_TIMEOUT, 100000: max cycles from accepted command to cmd_done before error.

Ports:
- clk  in  1  system clock (FCCC GL0)
- rst  in  1  asynchronous active-low reset
- restart  in  1  single-cycle pulse; re-runs the full sequence, honoured only in S_DONE
- rom_addr  out  ROM_AW  table index
- rom_data  in  16  table entry {reg[15:8], val[7:0]}, valid one cycle after rom_addr changes
- cmd_valid  out  1  write command valid
- cmd_ready  in  1  SCCB master accepts command
- cmd_reg  out  8  register address
- cmd_data  out  8  register value
- cmd_done  in  1  one-cycle pulse when the SCCB write completes
- ov7670_rst_n  out  1  sensor reset, active low
- ov7670_pwdn  out  1  sensor power-down, active high
- done  out  1  sequence finished (success or error)
- error  out  1  timeout or missing end marker

Behaviour:
- Reset values: ov7670_pwdn=1, ov7670_rst_n=0, cmd_valid=0, cmd_reg=0, cmd_data=0, rom_addr=0, done=0, error=0. State is S_RST.
- Asserting rst at any point aborts immediately and returns to these values. cmd_valid drops asynchronously.
- Delay timing uses a prescaler counting 0..MS_CYCLES-1 plus an 8-bit ms counter. The prescaler clears on every state entry.
- S_RST: pwdn=1, rst_n=0. After RST_LOW_MS ms, go to S_PWRUP.
- S_PWRUP: pwdn=0, rst_n=1. After PWRUP_MS ms, set rom_addr=0 and go to S_FETCH.
- S_FETCH: one wait cycle for ROM latency, then go to S_DECODE.
- S_DECODE, decoding rom_data:
  - 16'hFFFF: go to S_DONE, error=0.
  - reg==8'hF0: delay entry.
    - val==0: advance index and go to S_NEXT.
    - Otherwise go to S_DELAY for val ms.
  - Anything else: latch cmd_reg/cmd_data and go to S_CMD.
- S_CMD: cmd_valid=1, with cmd_reg/cmd_data held stable.
  - Transfer occurs on the cycle where cmd_valid & cmd_ready are both high.
  - On that cycle, cmd_valid=0 on the next edge and go to S_WAIT.
  - cmd_valid never drops before the transfer.
- S_WAIT: wait for cmd_done and count cycles.
  - cmd_done seen: go to S_NEXT.
  - Count reaches ACK_TIMEOUT: error=1, go to S_DONE.
  - cmd_done arriving in the same cycle the count hits the limit counts as success.
- S_DELAY: wait val ms, then go to S_NEXT.
- S_NEXT: if rom_addr == 2^ROM_AW-1 (no end marker found), error=1 and go to S_DONE. Otherwise rom_addr+1 and go to S_FETCH. rom_addr never wraps.
- S_DONE: done=1, and pins stay pwdn=0, rst_n=1.
  - restart pulse: clear done and error, rom_addr=0, go to S_RST.
  - restart in any other state is ignored.
- A cmd_done pulse outside S_WAIT is ignored.
- cmd_ready outside S_CMD is ignored.
- Per-entry overhead outside handshakes: FETCH+DECODE+NEXT = 3 cycles.

Test Plan:
1. Power-up timing (MS_CYCLES=10, RST_LOW_MS=1, PWRUP_MS=3), release rst → rst_n=0 and pwdn=1 for exactly 10 cycles; then both released; first rom_addr fetch occurs 30 cycles later.
2. Table {1280, 1100, FFFF} with cmd_ready tied high and cmd_done 5 cycles after each accept → exactly two transfers, reg/data 12/80 then 11/00; done=1, error=0; rom_addr stops at 2.
3. Backpressure: cmd_ready low for 7 cycles on the first command → cmd_valid stays high with 12/80 stable for all 7 cycles; single transfer.
4. Table {F002, 3A04, FFFF} → no command for 20 cycles after decoding F002; then 3A/04 is issued. Separately, F000 adds no delay.
5. Timeout: ACK_TIMEOUT=50, cmd_done never asserted → done=1 and error=1 at 50 cycles after accept. restart pulse → done=0, pins go back to pwdn=1/rst_n=0, and the sequence reruns.
6. Reset mid-command: assert rst while in S_CMD with cmd_ready low → cmd_valid drops immediately, all outputs take reset values, and the full sequence reruns after release. A ROM with no FFFF (ROM_AW=2) → error=1 after index 3.
